// File: rtl/bin2asc_pkg.sv
// rtl/bin2asc_pkg.sv - shared state encoding and ASCII constants for bin2asc_stream (BIN2ASC_STREAM_PREFIX_EN adds PREFIX)
package bin2asc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef BIN2ASC_STREAM_PREFIX_EN
        ST_PREFIX = 2'd1,
`endif
        ST_DIGITS = 2'd2
    } state_t;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_X  = 8'h78;
    localparam logic [7:0] ASC_UA = 8'h41;
    localparam logic [7:0] ASC_LA = 8'h61;

endpackage

// File: rtl/bin2asc_nib.sv
// rtl/bin2asc_nib.sv - nibble to uppercase ASCII hex digit converter
module bin2asc_nib
    import bin2asc_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] asc
);

    always_comb begin
        if (nib < 4'd10) asc = ASC_0 + {4'h0, nib};
        else             asc = ASC_UA + {4'h0, nib} - 8'd10;
    end

endmodule

// File: rtl/bin2asc_stream.sv
// rtl/bin2asc_stream.sv - binary word to ASCII hex character stream; BIN2ASC_STREAM_PREFIX_EN adds a "0x" prefix
module bin2asc_stream
    import bin2asc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit LOWER = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_zsup,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(NIB - 1);

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [IW-1:0]    idx;
`ifdef BIN2ASC_STREAM_PREFIX_EN
    logic             pfx_cnt;
`endif

    logic [IW-1:0]    start_idx, nxt_idx, sel_idx;
    logic [WIDTH-1:0] sel_data;
    logic [3:0]       nib;
    logic [7:0]       asc_raw, asc;

    function automatic logic [3:0] nib_at(input logic [WIDTH-1:0] d, input logic [IW-1:0] i);
        nib_at = 4'h0;
        for (int k = 0; k < NIB; k++)
            if (i == IW'(k)) nib_at = d[4*k +: 4];
    endfunction

    function automatic logic [IW-1:0] msnz(input logic [WIDTH-1:0] d);
        msnz = '0;
        for (int k = 0; k < NIB; k++)
            if (d[4*k +: 4] != 4'h0) msnz = IW'(k);
    endfunction

    // The converter always looks at the character to be registered next:
    // the first digit of the incoming word in IDLE, otherwise the stored word.
    always_comb begin
        start_idx = in_zsup ? msnz(in_data) : TOP_IDX;
        nxt_idx   = (idx == '0) ? '0 : idx - IW'(1);
        sel_data  = data_q;
        sel_idx   = nxt_idx;
        case (state)
            ST_IDLE: begin
                sel_data = in_data;
                sel_idx  = start_idx;
            end
`ifdef BIN2ASC_STREAM_PREFIX_EN
            ST_PREFIX: sel_idx = idx;
`endif
            default: ;
        endcase
        nib = nib_at(sel_data, sel_idx);
    end

    bin2asc_nib u_nib (
        .nib (nib),
        .asc (asc_raw)
    );

    assign asc = (LOWER && nib > 4'd9) ? asc_raw - ASC_UA + ASC_LA : asc_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            idx       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
`ifdef BIN2ASC_STREAM_PREFIX_EN
            pfx_cnt   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_ready && in_valid) begin
                        data_q    <= in_data;
                        idx       <= start_idx;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
`ifdef BIN2ASC_STREAM_PREFIX_EN
                        state     <= ST_PREFIX;
                        pfx_cnt   <= 1'b0;
                        out_char  <= ASC_0;
                        out_last  <= 1'b0;
`else
                        state     <= ST_DIGITS;
                        out_char  <= asc;
                        out_last  <= (start_idx == '0);
`endif
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
`ifdef BIN2ASC_STREAM_PREFIX_EN
                ST_PREFIX: begin
                    if (out_ready) begin
                        if (!pfx_cnt) begin
                            pfx_cnt  <= 1'b1;
                            out_char <= ASC_X;
                        end else begin
                            state    <= ST_DIGITS;
                            out_char <= asc;
                            out_last <= (idx == '0);
                        end
                    end
                end
`endif
                ST_DIGITS: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= ST_IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_char  <= 8'h00;
                        end else begin
                            idx       <= nxt_idx;
                            out_char  <= asc;
                            out_last  <= (nxt_idx == '0);
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    out_char  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2asc_stream.sv
// tb/tb_bin2asc_stream.sv - directed table-driven bench for bin2asc_stream (honours BIN2ASC_STREAM_PREFIX_EN)
module tb_bin2asc_stream;

`ifdef BIN2ASC_STREAM_PREFIX_EN
    localparam int PFX = 2;
`else
    localparam int PFX = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_zsup = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  sel = 2'd0;

    logic       ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3, ol0, ol1, ol2, ol3;
    logic [7:0] oc0, oc1, oc2, oc3;
    logic       ir, ov, ol;
    logic [7:0] oc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin2asc_stream #(.WIDTH(32), .LOWER(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2'd0), .in_ready(ir0),
        .in_data(in_data), .in_zsup(in_zsup), .out_valid(ov0), .out_ready(out_ready),
        .out_char(oc0), .out_last(ol0));
    bin2asc_stream #(.WIDTH(32), .LOWER(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2'd1), .in_ready(ir1),
        .in_data(in_data), .in_zsup(in_zsup), .out_valid(ov1), .out_ready(out_ready),
        .out_char(oc1), .out_last(ol1));
    bin2asc_stream #(.WIDTH(8), .LOWER(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2'd2), .in_ready(ir2),
        .in_data(in_data[7:0]), .in_zsup(in_zsup), .out_valid(ov2), .out_ready(out_ready),
        .out_char(oc2), .out_last(ol2));
    bin2asc_stream #(.WIDTH(16), .LOWER(1'b0)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2'd3), .in_ready(ir3),
        .in_data(in_data[15:0]), .in_zsup(in_zsup), .out_valid(ov3), .out_ready(out_ready),
        .out_char(oc3), .out_last(ol3));

    always_comb begin
        ir = ir0; ov = ov0; ol = ol0; oc = oc0;
        case (sel)
            2'd1: begin ir = ir1; ov = ov1; ol = ol1; oc = oc1; end
            2'd2: begin ir = ir2; ov = ov2; ol = ol2; oc = oc2; end
            2'd3: begin ir = ir3; ov = ov3; ol = ol3; oc = oc3; end
            default: ;
        endcase
    end

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic        zsup;
        logic [63:0] exp;
        int          n;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_char(input logic [63:0] ex, input int n, input int i);
        if (i < PFX) return (i == 0) ? 8'h30 : 8'h78;
        return ex[8*(n-1-(i-PFX)) +: 8];
    endfunction

    task automatic run_word(input logic [1:0] s, input logic [31:0] d, input logic z,
                            input logic [63:0] ex, input int n, input bit stall,
                            input bit hold, input logic [31:0] next_d, input string nm);
        int got, cyc, waitc;
        logic [7:0] pc;
        logic pl;
        bit pstall;
        sel = s;
        waitc = 0;
        while (!ir && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        chk({nm, "_ready"}, 64'(ir), 64'd1);
        in_data = d;
        in_zsup = z;
        in_valid = 1'b1;
        out_ready = stall ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        if (hold) in_data = next_d;
        else in_valid = 1'b0;
        chk({nm, "_latency"}, 64'(ov), 64'd1);
        got = 0; cyc = 0; pstall = 0; pc = '0; pl = 1'b0;
        while (got < n + PFX && cyc < 200) begin
            if (pstall) begin
                chk({nm, "_stall_valid"}, 64'(ov), 64'd1);
                chk({nm, "_stall_char"}, 64'(oc), 64'(pc));
                chk({nm, "_stall_last"}, 64'(ol), 64'(pl));
            end
            pstall = ov && !out_ready;
            pc = oc;
            pl = ol;
            if (ov && out_ready) begin
                chk({nm, "_char"}, 64'(oc), 64'(exp_char(ex, n, got)));
                chk({nm, "_last"}, 64'(ol), 64'(got == n + PFX - 1));
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (stall) out_ready = !out_ready;
        end
        chk({nm, "_count"}, 64'(got), 64'(n + PFX));
        if (stall) chk({nm, "_cycles"}, 64'(cyc), 64'(2 * (n + PFX)));
        chk({nm, "_ready_after"}, 64'(ir), 64'd1);
        chk({nm, "_idle_valid"}, 64'(ov), 64'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2'd0, 32'h1234ABCD, 1'b0, 64'("1234ABCD"), 8};
        tbl[1]  = '{2'd0, 32'h000000F0, 1'b0, 64'("000000F0"), 8};
        tbl[2]  = '{2'd0, 32'h000000F0, 1'b1, 64'("F0"), 2};
        tbl[3]  = '{2'd1, 32'h000000F0, 1'b1, 64'("f0"), 2};
        tbl[4]  = '{2'd1, 32'h00000000, 1'b1, 64'("0"), 1};
        tbl[5]  = '{2'd0, 32'h00000000, 1'b0, 64'("00000000"), 8};
        tbl[6]  = '{2'd3, 32'h000000FF, 1'b1, 64'("FF"), 2};
        tbl[7]  = '{2'd2, 32'h0000005A, 1'b0, 64'("5A"), 2};
        tbl[8]  = '{2'd2, 32'h00000005, 1'b1, 64'("5"), 1};
        tbl[9]  = '{2'd1, 32'hFEDCBA98, 1'b1, 64'("fedcba98"), 8};
        tbl[10] = '{2'd0, 32'h80000000, 1'b1, 64'("80000000"), 8};
        tbl[11] = '{2'd3, 32'h00001000, 1'b1, 64'("1000"), 4};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ov0 | ov1 | ov2 | ov3), 64'd0);
        chk("rst_last", 64'(ol0 | ol1 | ol2 | ol3), 64'd0);
        chk("rst_char", 64'({oc0, oc1, oc2, oc3}), 64'd0);
        chk("rst_ready", 64'(ir0 | ir1 | ir2 | ir3), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 64'(ir0), 64'd0);
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(ir0 & ir1 & ir2 & ir3), 64'd1);

        for (int i = 0; i < 12; i++)
            run_word(tbl[i].sel, tbl[i].data, tbl[i].zsup, tbl[i].exp, tbl[i].n,
                     1'b0, 1'b0, 32'h0, $sformatf("vec%0d", i));

        run_word(2'd2, 32'h0000005A, 1'b0, 64'("5A"), 2, 1'b1, 1'b0, 32'h0, "stall_5a");

        sel = 2'd0;
        in_data = 32'hDEADBEEF;
        in_zsup = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midword_valid", 64'(ov0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(ov0), 64'd0);
        chk("async_rst_last", 64'(ol0), 64'd0);
        chk("async_rst_char", 64'(oc0), 64'd0);
        chk("async_rst_ready", 64'(ir0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_midrst", 64'(ir0), 64'd1);
        run_word(2'd0, 32'h00000001, 1'b0, 64'("00000001"), 8, 1'b0, 1'b0, 32'h0, "post_rst");

        run_word(2'd0, 32'h00000001, 1'b0, 64'("00000001"), 8, 1'b0, 1'b1, 32'h2, "hold1");
        run_word(2'd0, 32'h00000002, 1'b0, 64'("00000002"), 8, 1'b0, 1'b0, 32'h0, "hold2");

        in_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2asc_stream.md
BIN2ASC_STREAM -- requirements
Module: bin2asc_stream

Interface
REQ-001 Parameter WIDTH, default 32, input word width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter LOWER, default 0; 1 SHALL select lowercase hex letters 'a'-'f', 0 SHALL select uppercase 'A'-'F'.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data and in_zsup are valid.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 in_data  input  WIDTH  binary word to convert.
REQ-008 in_zsup  input  1  leading-zero suppression for this word.
REQ-009 out_valid  output  1  out_char holds a character.
REQ-010 out_ready  input  1  sink accepts out_char.
REQ-011 out_char  output  8  ASCII character.
REQ-012 out_last  output  1  out_char is the final character of the current word.

Function
REQ-013 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_data and in_zsup SHALL be latched at that edge.
REQ-014 in_ready SHALL be 1 only in state IDLE; there is exactly one idle cycle between words.
REQ-015 States: IDLE, PREFIX, DIGITS; transitions: IDLE->PREFIX on accept if the prefix is compiled in, else IDLE->DIGITS; PREFIX->DIGITS after the second prefix character handshakes; DIGITS->IDLE when the character with out_last=1 handshakes.
REQ-016 The first character SHALL appear with out_valid=1 in the cycle after acceptance (one-cycle latency); all outputs SHALL be registered.
REQ-017 Digits SHALL be emitted most-significant nibble first, one character per out_valid&&out_ready handshake; nibble values 0-9 map to 8'h30-8'h39, 10-15 to 8'h41-8'h46 (LOWER=0) or 8'h61-8'h66 (LOWER=1).
REQ-018 Without suppression, exactly WIDTH/4 digits SHALL be emitted.
REQ-019 With in_zsup=1, emission SHALL start at the most-significant nonzero nibble; an all-zero word SHALL emit exactly one '0'.
REQ-020 While out_valid=1 and out_ready=0, out_char and out_last SHALL hold stable and out_valid SHALL stay 1.
REQ-021 out_last SHALL be 1 only on the final digit; it SHALL never be 1 on a prefix character.
REQ-022 The nibble index counter SHALL be $clog2(WIDTH/4) bits wide, minimum 1 bit, and SHALL never wrap past the least-significant nibble.
REQ-023 in_valid while not in IDLE SHALL be ignored without side effects.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, out_valid=0, out_last=0, out_char=8'h00, in_ready=0, and counter 0, including mid-word; the partial word SHALL be discarded.
REQ-025 in_ready SHALL rise to 1 in the first clock cycle after rst_n deasserts.

Configuration
REQ-026 Macro BIN2ASC_STREAM_PREFIX_EN defined: every word SHALL be preceded by '0' (8'h30) then 'x' (8'h78), with 2 extra handshakes per word; latency to the first '0' SHALL be 1 cycle.
REQ-027 Macro undefined: PREFIX state and its logic SHALL be absent, and output SHALL be digits only.

Structure
REQ-028 Package bin2asc_pkg SHALL hold the state enum and the ASCII constants (ASC_0, ASC_X, ASC_UA, ASC_LA).
REQ-029 Nibble-to-ASCII conversion SHALL use one instance of the existing bin2asc nibble converter; its output SHALL be case-adjusted for LOWER=1.

Verification
REQ-030 WIDTH=32, in_data=32'h1234ABCD, zsup=0, out_ready=1 -> "1234ABCD" on consecutive cycles starting 1 cycle after accept, last='D', in_ready high the following cycle.
REQ-031 WIDTH=32, in_data=32'h000000F0, zsup=1, LOWER=1 -> "f0" (8'h66,8'h30), out_last on '0'; in_data=0, zsup=1 -> single '0' with out_last=1.
REQ-032 WIDTH=8, in_data=8'h5A, out_ready toggling 0/1 every cycle -> "5A" intact, out_char stable during each stall, 4 cycles from first valid to last handshake.
REQ-033 PREFIX_EN defined, WIDTH=16, in_data=16'h00FF, zsup=1 -> "0xFF", out_last only on the second 'F'.
REQ-034 rst_n pulsed low after 3 of 8 chars of 32'hDEADBEEF -> out_valid drops asynchronously; the next word 32'h00000001 emits "00000001" cleanly.
REQ-035 in_valid held high continuously with words 32'h1 and 32'h2 -> each accepted only in IDLE, with no character loss or merging.
